// File: rtl/vga_pkg.sv
// Package: vga_pkg
// Purpose: Shared timing constants and region decode for the 640x480@60 raster.
//   - Default horizontal/vertical timing (active, front porch, sync, back porch)
//   - Derived line/frame totals and sync region bounds
//   - region_t enum plus region_of() helper that classifies a counter value
package vga_pkg;

  // Default 640x480@60 timing (pixel clock 25 MHz)
  localparam int H_VID  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;
  localparam int V_VID  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  // Derived totals and sync bounds (sync region is [START, END))
  localparam int H_TOTAL      = H_VID + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_VID + V_FP + V_SYNC + V_BP;
  localparam int H_SYNC_START = H_VID + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VID + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  // Position of a counter within its line/frame; shared by both directions
  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } region_t;

  // Bounds are 11 bits wide so a total of exactly 1024 still fits.
  function automatic region_t region_of(
    input logic [9:0]  pos,
    input logic [10:0] vid_end,
    input logic [10:0] fp_end,
    input logic [10:0] sync_end
  );
    logic [10:0] p;
    region_t     r;
    p = {1'b0, pos};
    if (p < vid_end) begin
      r = ACTIVE;
    end else if (p < fp_end) begin
      r = FRONT;
    end else if (p < sync_end) begin
      r = SYNC;
    end else begin
      r = BACK;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Module: sync_delay_line
// Purpose: DEPTH-stage single-bit shift register used to retime sync pulses.
//   DEPTH = 0 is a straight wire. Stages advance only when en is high and
//   are all loaded with flush_value on srst (synchronous, active-high).
// Ports:
//   clk         - clock
//   srst        - synchronous active-high flush
//   en          - advance enable; low holds every stage
//   flush_value - level every stage takes on srst
//   d           - serial input
//   q           - output, d delayed by DEPTH enabled clocks
module sync_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic srst,
  input  logic en,
  input  logic flush_value,
  input  logic d,
  output logic q
);

  if (DEPTH == 0) begin : g_bypass
    assign q = d;
  end else begin : g_pipe
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic stage_reg;
      logic stage_in;

      if (gi == 0) begin : g_first
        assign stage_in = d;
      end else begin : g_rest
        assign stage_in = g_stage[gi-1].stage_reg;
      end

      always_ff @(posedge clk) begin
        if (srst) begin
          stage_reg <= flush_value;
        end else if (en) begin
          stage_reg <= stage_in;
        end
      end
    end

    assign q = g_stage[DEPTH-1].stage_reg;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Module: vga_timing_gen
// Purpose: Raster timing for the colour generator. Pixel/line counters,
//   active-video decode, line/frame strobes, a frame counter, and hsync/vsync
//   delayed to line up with the downstream RGB register.
// Ports:
//   clk_25         - pixel clock
//   reset          - synchronous active-high reset (priority over en)
//   en             - clock enable; low freezes every register
//   horizontal_num - pixel counter 0..HTOTAL-1
//   vertical_num   - line counter 0..VTOTAL-1
//   video_on       - high inside the active area
//   load_enable    - inverse of video_on, blanks downstream colour
//   hsync, vsync   - sync outputs, SYNC_DELAY clocks behind the counters
//   line_start     - high while horizontal_num == 0
//   frame_start    - high while both counters are 0
//   frame_count    - frames started since reset, wraps 255 -> 0
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int HVID       = H_VID,
  parameter int HFP        = H_FP,
  parameter int HSYNC      = H_SYNC,
  parameter int HBP        = H_BP,
  parameter int VVID       = V_VID,
  parameter int VFP        = V_FP,
  parameter int VSYNC      = V_SYNC,
  parameter int VBP        = V_BP,
  parameter bit SYNC_POL   = 1'b0,
  parameter int SYNC_DELAY = 1
) (
  input  logic       clk_25,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] horizontal_num,
  output logic [9:0] vertical_num,
  output logic       video_on,
  output logic       load_enable,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int HTOTAL = HVID + HFP + HSYNC + HBP;
  localparam int VTOTAL = VVID + VFP + VSYNC + VBP;

  localparam logic [9:0]  H_LAST     = 10'(HTOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(VTOTAL - 1);
  localparam logic [10:0] H_VID_END  = 11'(HVID);
  localparam logic [10:0] H_FP_END   = 11'(HVID + HFP);
  localparam logic [10:0] H_SYNC_END_B = 11'(HVID + HFP + HSYNC);
  localparam logic [10:0] V_VID_END  = 11'(VVID);
  localparam logic [10:0] V_FP_END   = 11'(VVID + VFP);
  localparam logic [10:0] V_SYNC_END_B = 11'(VVID + VFP + VSYNC);

  logic [9:0] h_reg, h_next;
  logic [9:0] v_reg, v_next;
  logic       video_on_reg, video_on_next;
  logic       line_start_reg, line_start_next;
  logic       frame_start_reg, frame_start_next;
  logic [7:0] frame_count_reg, frame_count_next;
  logic       hsync_raw_reg, hsync_raw_next;
  logic       vsync_raw_reg, vsync_raw_next;
  region_t    h_region_next, v_region_next;

  // Decode from the next-state counters so every registered output lands in
  // the same cycle as the counter value it describes.
  always_comb begin
    h_next = h_reg + 10'd1;
    v_next = v_reg;
    // >= rather than == keeps the counters in range even from a bad value.
    if (h_reg >= H_LAST) begin
      h_next = '0;
      v_next = (v_reg >= V_LAST) ? 10'd0 : v_reg + 10'd1;
    end

    h_region_next = region_of(h_next, H_VID_END, H_FP_END, H_SYNC_END_B);
    v_region_next = region_of(v_next, V_VID_END, V_FP_END, V_SYNC_END_B);

    video_on_next    = (h_region_next == ACTIVE) && (v_region_next == ACTIVE);
    line_start_next  = (h_next == 10'd0);
    frame_start_next = line_start_next && (v_next == 10'd0);
    frame_count_next = frame_start_next ? frame_count_reg + 8'd1 : frame_count_reg;

    // vertical region only moves when h wraps, so vsync changes only at h == 0
    hsync_raw_next = (h_region_next == SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_raw_next = (v_region_next == SYNC) ? SYNC_POL : ~SYNC_POL;
  end

  // Reset parks the counters on the last position so the first enabled edge
  // produces (0,0) together with frame_start and frame_count = 0.
  always_ff @(posedge clk_25) begin
    if (reset) begin
      h_reg           <= H_LAST;
      v_reg           <= V_LAST;
      video_on_reg    <= 1'b0;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_count_reg <= 8'hFF;
      hsync_raw_reg   <= ~SYNC_POL;
      vsync_raw_reg   <= ~SYNC_POL;
    end else if (en) begin
      h_reg           <= h_next;
      v_reg           <= v_next;
      video_on_reg    <= video_on_next;
      line_start_reg  <= line_start_next;
      frame_start_reg <= frame_start_next;
      frame_count_reg <= frame_count_next;
      hsync_raw_reg   <= hsync_raw_next;
      vsync_raw_reg   <= vsync_raw_next;
    end
  end

  // Sync retiming; flushed to the inactive level so a reset never leaves a
  // partial pulse draining out of the pipe.
  sync_delay_line #(
    .DEPTH(SYNC_DELAY)
  ) u_hsync_delay (
    .clk        (clk_25),
    .srst       (reset),
    .en         (en),
    .flush_value(~SYNC_POL),
    .d          (hsync_raw_reg),
    .q          (hsync)
  );

  sync_delay_line #(
    .DEPTH(SYNC_DELAY)
  ) u_vsync_delay (
    .clk        (clk_25),
    .srst       (reset),
    .en         (en),
    .flush_value(~SYNC_POL),
    .d          (vsync_raw_reg),
    .q          (vsync)
  );

  assign horizontal_num = h_reg;
  assign vertical_num   = v_reg;
  assign video_on       = video_on_reg;
  assign load_enable    = ~video_on_reg;
  assign line_start     = line_start_reg;
  assign frame_start    = frame_start_reg;
  assign frame_count    = frame_count_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench: tb_vga_timing_gen
// Purpose: Drives three vga_timing_gen instances from shared reset/en:
//   A - default 640x480 timing, SYNC_DELAY = 1
//   B - small timing (16x7), SYNC_DELAY = 0
//   C - small timing (16x7), SYNC_DELAY = 2
// Each cycle a timing model predicts every output; predictions are queued
// when inputs are driven and compared after the next clock edge. Directed
// checks cover reset values, line/frame lengths, enable freeze, frame counter
// wrap and mid-frame reset.
module tb_vga_timing_gen;
  import vga_pkg::*;

  typedef struct {
    int h; int v; int vid; int le; int hs; int vs; int ls; int fs; int fc;
  } obs_t;

  typedef struct {
    int hvid; int hfp; int hsw; int hbp; int vvid; int vfp; int vsw; int vbp; int pol; int dly;
  } tim_t;

  typedef struct {
    int h; int v; int fc; int vid; int ls; int fs;
    logic rh; logic rv; logic [3:0] ph; logic [3:0] pv;
  } mdl_t;

  logic clk_25 = 1'b0;
  logic reset  = 1'b1;
  logic en     = 1'b1;

  logic [9:0] a_h, a_v, b_h, b_v, c_h, c_v;
  logic       a_vid, a_le, a_hs, a_vs, a_ls, a_fs;
  logic       b_vid, b_le, b_hs, b_vs, b_ls, b_fs;
  logic       c_vid, c_le, c_hs, c_vs, c_ls, c_fs;
  logic [7:0] a_fc, b_fc, c_fc;

  int n_checks = 0;
  int n_pass   = 0;

  tim_t ta, tb_t, tc;
  mdl_t ma, mb, mc;
  obs_t q_a[$], q_b[$], q_c[$];

  always #20 clk_25 = ~clk_25;

  vga_timing_gen u_a (
    .clk_25(clk_25), .reset(reset), .en(en),
    .horizontal_num(a_h), .vertical_num(a_v), .video_on(a_vid), .load_enable(a_le),
    .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_timing_gen #(
    .HVID(8), .HFP(2), .HSYNC(3), .HBP(3), .VVID(4), .VFP(1), .VSYNC(1), .VBP(1),
    .SYNC_POL(1'b0), .SYNC_DELAY(0)
  ) u_b (
    .clk_25(clk_25), .reset(reset), .en(en),
    .horizontal_num(b_h), .vertical_num(b_v), .video_on(b_vid), .load_enable(b_le),
    .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_timing_gen #(
    .HVID(8), .HFP(2), .HSYNC(3), .HBP(3), .VVID(4), .VFP(1), .VSYNC(1), .VBP(1),
    .SYNC_POL(1'b0), .SYNC_DELAY(2)
  ) u_c (
    .clk_25(clk_25), .reset(reset), .en(en),
    .horizontal_num(c_h), .vertical_num(c_v), .video_on(c_vid), .load_enable(c_le),
    .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference behaviour of one enabled/reset clock edge.
  function automatic mdl_t step(input mdl_t m, input logic rst, input logic e, input tim_t t);
    mdl_t n;
    int   ht, vt, hs0, vs0;
    logic act, inact;
    n     = m;
    ht    = t.hvid + t.hfp + t.hsw + t.hbp;
    vt    = t.vvid + t.vfp + t.vsw + t.vbp;
    hs0   = t.hvid + t.hfp;
    vs0   = t.vvid + t.vfp;
    act   = (t.pol != 0);
    inact = ~act;
    if (rst) begin
      n.h = ht - 1; n.v = vt - 1; n.fc = 255;
      n.vid = 0; n.ls = 0; n.fs = 0;
      n.rh = inact; n.rv = inact;
      n.ph = {4{inact}}; n.pv = {4{inact}};
    end else if (e) begin
      n.ph = {m.ph[2:0], m.rh};
      n.pv = {m.pv[2:0], m.rv};
      n.h  = (m.h == ht - 1) ? 0 : m.h + 1;
      if (n.h == 0) n.v = (m.v == vt - 1) ? 0 : m.v + 1;
      n.vid = (n.h < t.hvid && n.v < t.vvid) ? 1 : 0;
      n.ls  = (n.h == 0) ? 1 : 0;
      n.fs  = (n.h == 0 && n.v == 0) ? 1 : 0;
      if (n.fs == 1) n.fc = (m.fc + 1) % 256;
      n.rh = (n.h >= hs0 && n.h < hs0 + t.hsw) ? act : inact;
      n.rv = (n.v >= vs0 && n.v < vs0 + t.vsw) ? act : inact;
    end
    return n;
  endfunction

  function automatic obs_t expect_of(input mdl_t m, input tim_t t);
    obs_t o;
    o.h = m.h; o.v = m.v; o.vid = m.vid; o.le = 1 - m.vid;
    o.ls = m.ls; o.fs = m.fs; o.fc = m.fc;
    o.hs = (t.dly == 0) ? int'(m.rh) : int'(m.ph[t.dly-1]);
    o.vs = (t.dly == 0) ? int'(m.rv) : int'(m.pv[t.dly-1]);
    return o;
  endfunction

  task automatic cmp(input string nm, input obs_t o, input obs_t e);
    check({nm, ".h"},   o.h,   e.h);
    check({nm, ".v"},   o.v,   e.v);
    check({nm, ".vid"}, o.vid, e.vid);
    check({nm, ".le"},  o.le,  e.le);
    check({nm, ".hs"},  o.hs,  e.hs);
    check({nm, ".vs"},  o.vs,  e.vs);
    check({nm, ".ls"},  o.ls,  e.ls);
    check({nm, ".fs"},  o.fs,  e.fs);
    check({nm, ".fc"},  o.fc,  e.fc);
  endtask

  // Inputs are already stable; predict, clock, then compare 1 ns after edge.
  task automatic tick();
    obs_t o;
    ma = step(ma, reset, en, ta);   q_a.push_back(expect_of(ma, ta));
    mb = step(mb, reset, en, tb_t); q_b.push_back(expect_of(mb, tb_t));
    mc = step(mc, reset, en, tc);   q_c.push_back(expect_of(mc, tc));
    @(posedge clk_25);
    #1;
    o = '{int'(a_h), int'(a_v), int'(a_vid), int'(a_le), int'(a_hs), int'(a_vs),
          int'(a_ls), int'(a_fs), int'(a_fc)};
    cmp("A", o, q_a.pop_front());
    o = '{int'(b_h), int'(b_v), int'(b_vid), int'(b_le), int'(b_hs), int'(b_vs),
          int'(b_ls), int'(b_fs), int'(b_fc)};
    cmp("B", o, q_b.pop_front());
    o = '{int'(c_h), int'(c_v), int'(c_vid), int'(c_le), int'(c_hs), int'(c_vs),
          int'(c_ls), int'(c_fs), int'(c_fc)};
    cmp("C", o, q_c.pop_front());
  endtask

  initial begin
    int hs_low, hs_first, vid_cnt, ls_first, ls_second;
    int b_vs_low, c_vs_low, b_fs_cnt, b_fs_last, b_gap_bad, prev_bh, prev_bv;
    int guard, c_low;
    region_t hr;

    ta   = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 1};
    tb_t = '{8, 2, 3, 3, 4, 1, 1, 1, 0, 0};
    tc   = '{8, 2, 3, 3, 4, 1, 1, 1, 0, 2};
    ma = '{0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 4'hF, 4'hF};
    mb = ma;
    mc = ma;

    // Reset held three cycles with en high
    reset = 1'b1; en = 1'b1;
    repeat (3) tick();
    check("rst_a_h", int'(a_h), 799);
    check("rst_a_v", int'(a_v), 524);
    check("rst_a_vid", int'(a_vid), 0);
    check("rst_a_le", int'(a_le), 1);
    check("rst_a_hs", int'(a_hs), 1);
    check("rst_a_vs", int'(a_vs), 1);
    check("rst_a_fc", int'(a_fc), 255);
    check("rst_b_h", int'(b_h), 15);
    check("rst_b_v", int'(b_v), 6);

    // First enabled edge after release
    reset = 1'b0;
    tick();
    check("first_h", int'(a_h), 0);
    check("first_v", int'(a_v), 0);
    check("first_vid", int'(a_vid), 1);
    check("first_fs", int'(a_fs), 1);
    check("first_ls", int'(a_ls), 1);
    check("first_fc", int'(a_fc), 0);

    // Two lines of A (h=1..799, 0..799, 0) and three frames of B/C
    hs_low = 0; hs_first = -1; vid_cnt = 0; ls_first = -1; ls_second = -1;
    b_vs_low = 0; c_vs_low = 0; b_fs_cnt = 0; b_fs_last = -1; b_gap_bad = 0;
    prev_bh = int'(b_h); prev_bv = int'(b_v);
    for (int i = 0; i < 1600; i++) begin
      tick();
      hr = (a_h < 10'd640) ? ACTIVE : (a_h < 10'd656) ? FRONT : (a_h < 10'd752) ? SYNC : BACK;
      check("a_vid_region", int'(a_vid), (hr == ACTIVE) ? 1 : 0);
      if (a_hs == 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(a_h);
      end
      if (a_vid) vid_cnt++;
      if (a_ls) begin
        if (ls_first < 0) ls_first = i;
        else if (ls_second < 0) ls_second = i;
      end
      if (i < 336) begin
        if (b_vs == 1'b0) b_vs_low++;
        if (c_vs == 1'b0) c_vs_low++;
        if (b_fs) begin
          b_fs_cnt++;
          check("b_wrap_from_h", prev_bh, 15);
          check("b_wrap_from_v", prev_bv, 6);
          if (b_fs_last >= 0 && i - b_fs_last != 112) b_gap_bad++;
          b_fs_last = i;
        end
        if (i == 335) check("b_fc_3frames", int'(b_fc), 3);
      end
      prev_bh = int'(b_h); prev_bv = int'(b_v);
    end
    check("a_hs_low_cycles", hs_low, 192);
    check("a_hs_first_low_h", hs_first, 657);
    check("a_vid_cycles", vid_cnt, 1280);
    check("a_line_period", ls_second - ls_first, 800);
    check("b_vs_low_cycles", b_vs_low, 48);
    check("c_vs_low_cycles", c_vs_low, 48);
    check("b_fs_count", b_fs_cnt, 3);
    check("b_fs_period_bad", b_gap_bad, 0);

    // Enable freeze at A (300,10)
    guard = 0;
    while (!(ma.h == 300 && ma.v == 10) && guard < 10000) begin
      tick();
      guard++;
    end
    check("reach_a_300_10", (ma.h == 300 && ma.v == 10) ? 1 : 0, 1);
    en = 1'b0;
    repeat (5) tick();
    check("frz_a_h", int'(a_h), 300);
    check("frz_a_v", int'(a_v), 10);
    check("frz_a_hs", int'(a_hs), 1);
    en = 1'b1;
    tick();
    check("resume_a_h", int'(a_h), 301);

    // Frame counter wrap on B
    guard = 0;
    while (mb.fc != 255 && guard < 40000) begin
      tick();
      guard++;
    end
    check("reach_b_fc255", mb.fc, 255);
    guard = 0;
    while (mb.fc != 0 && guard < 200) begin
      tick();
      guard++;
    end
    check("b_fc_wrap", int'(b_fc), 0);
    check("b_fc_wrap_fs", int'(b_fs), 1);

    // Reset while B sits inside both hsync and vsync
    guard = 0;
    while (!(mb.h == 11 && mb.v == 5) && guard < 200) begin
      tick();
      guard++;
    end
    check("pre_rst_b_hs", int'(b_hs), 0);
    check("pre_rst_b_vs", int'(b_vs), 0);
    reset = 1'b1;
    tick();
    check("mid_rst_b_hs", int'(b_hs), 1);
    check("mid_rst_b_vs", int'(b_vs), 1);
    check("mid_rst_c_hs", int'(c_hs), 1);
    check("mid_rst_c_vs", int'(c_vs), 1);
    check("mid_rst_b_h", int'(b_h), 15);
    check("mid_rst_a_h", int'(a_h), 799);
    reset = 1'b0;
    c_low = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (c_hs == 1'b0 || c_vs == 1'b0) c_low++;
    end
    check("c_no_trailing_sync", c_low, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream stage of the colour generator. Produces the pixel/line counters, sync pulses and blanking control for the 640x480@60 raster on clk_25.
- horizontal_num and load_enable drive the colour block directly. hsync/vsync go to the DAC/connector, delayed to line up with the colour block's one-cycle RGB register.
- Also provides frame/line strobes and a frame counter for later animation stages.

Parameters:
- HVID, 640, active pixels per line
- HFP, 16, horizontal front porch (clocks)
- HSYNC, 96, hsync pulse width (clocks)
- HBP, 48, horizontal back porch (clocks)
- VVID, 480, active lines per frame
- VFP, 10, vertical front porch (lines)
- VSYNC, 2, vsync pulse width (lines)
- VBP, 33, vertical back porch (lines)
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
- SYNC_DELAY, 1, pipeline delay (clocks, 0..4) applied to hsync/vsync only

Ports:
- clk_25 input 1 pixel clock
- reset input 1 synchronous, active-high
- en input 1 clock enable; low freezes all state
- horizontal_num output 10 pixel counter, 0..HTOTAL-1
- vertical_num output 10 line counter, 0..VTOTAL-1
- video_on output 1 high in active area
- load_enable output 1 equals !video_on; blanks downstream colour
- hsync output 1 delayed horizontal sync
- vsync output 1 delayed vertical sync
- line_start output 1 one-cycle pulse when horizontal_num becomes 0
- frame_start output 1 one-cycle pulse when both counters become 0
- frame_count output 8 frames started since reset, wraps 255->0

Behaviour:
- One clock, clk_25. Reset is synchronous and active-high; the port is named reset. Reset has priority over en.
- HTOTAL = HVID+HFP+HSYNC+HBP (default 800). VTOTAL = VVID+VFP+VSYNC+VBP (default 525). Both must be ≤ 1024.
- Reset values:
  - horizontal_num = HTOTAL-1, vertical_num = VTOTAL-1
  - video_on = 0, load_enable = 1
  - hsync = vsync = !SYNC_POL; every stage of the delay pipe flushed to the inactive level
  - line_start = frame_start = 0, frame_count = 8'hFF
- As a result, the first enabled edge after reset goes to (0,0) with frame_start = 1 and frame_count = 0.
- Counter advance, per edge with en=1:
  - horizontal_num increments. At HTOTAL-1 it wraps to 0.
  - On that wrap, vertical_num increments. At VTOTAL-1 it wraps to 0.
- en=0: every register holds, including the sync delay pipe. Strobes hold their current value.
- Timing regions (h = horizontal_num, v = vertical_num):
  - active: h < HVID
  - hsync region: HVID+HFP ≤ h < HVID+HFP+HSYNC (default 656..751)
  - vsync region: VVID+VFP ≤ v < VVID+VFP+VSYNC (default 490..491); vsync changes only at h = 0
- Decoded outputs are registered from the next-state counter values, so they are cycle-aligned with the counter outputs (zero latency relative to horizontal_num):
  - video_on = (h < HVID) && (v < VVID); load_enable = !video_on
  - line_start = 1 iff h == 0
  - frame_start = 1 iff h == 0 && v == 0
  - frame_count increments in the same cycle frame_start rises
- hsync/vsync: the raw sync levels (SYNC_POL while in region, else !SYNC_POL) pass through a SYNC_DELAY-deep shift register advanced only when en=1. SYNC_DELAY = 0 bypasses the register, giving alignment with the counters.
- Reset mid-frame: next edge loads the reset values, with no partial pulses.
- Counters never take values ≥ HTOTAL/VTOTAL.

Decomposition:
- Package vga_pkg holds:
  - default timing localparams (640x480 set)
  - derived HTOTAL, VTOTAL and the hsync/vsync region bounds
  - a region enum {ACTIVE, FRONT, SYNC, BACK}, used by both directions and by the bench
- One sub-module: sync_delay_line (parameterised depth, enable, synchronous flush-to-value), instantiated for hsync and vsync.

Test Plan:
- Reset: hold reset 3 cycles with en=1.
  - During reset → h=799, v=524, video_on=0, load_enable=1, hsync=vsync=1.
  - First edge after release → h=0, v=0, video_on=1, frame_start=1, line_start=1, frame_count=0.
- Line: over one line →
  - video_on=1 through h=639, 0 at h=640
  - raw hsync low h=656..751; output hsync low h=657..752 (SYNC_DELAY=1), exactly 96 cycles
  - line_start every 800 cycles
- Frame: run 3 frames →
  - vsync low for 1600 consecutive cycles while v=490..491 (+1 delay)
  - frame_start exactly every 420000 cycles
  - frame_count 0→1→2
- Enable: drop en for 5 cycles at h=300, v=10 → all outputs frozen, including hsync/vsync pipe. The next enabled edge gives h=301.
- Reset mid-operation: reset at h=700, v=491 (inside hsync and vsync) → next cycle reset values, hsync=vsync=1 immediately, with no trailing sync pulse.
- Small-timing variant: HVID=8, HFP=2, HSYNC=3, HBP=3, VVID=4, VFP=1, VSYNC=1, VBP=1, SYNC_DELAY=0 →
  - line = 16 cycles, frame = 112 cycles
  - hsync low h=10..12, vsync low on v=5
  - frame wrap from (15,6) to (0,0)
